// File: rtl/candidate_sweeper.sv
// candidate_sweeper: drives the B input of an external equality comparator with
// candidates 0 .. 2^WIDTH-1, holds each for SETTLE cycles, and samples the
// comparator's match flag on the last settle cycle. Stops on the first match
// (found) or after the all-ones candidate (exhausted).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, dominates all inputs
//   start      begin a sweep (honoured in idle/done only)
//   abort      cancel an active sweep (honoured while searching only)
//   match      comparator equality flag for the current candidate
//   candidate  value presented to the comparator
//   busy       high while searching
//   found      sweep ended on a match
//   exhausted  sweep ended without a match
//   result     matching candidate when found, else 0
//   tries      candidates sampled in the current/last sweep
module candidate_sweeper #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             match,
  output logic [WIDTH-1:0] candidate,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   tries
);

  // Keep the settle counter at least one bit wide so SETTLE=1 still elaborates.
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] CandMax    = '1;

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             found_q, found_d;
  logic             exh_q, exh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   tries_q, tries_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    exh_d    = exh_q;
    result_d = result_q;
    tries_d  = tries_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StSearch;
          cand_d   = '0;
          cnt_d    = '0;
          tries_d  = '0;
          found_d  = 1'b0;
          exh_d    = 1'b0;
          result_d = '0;
        end
      end
      StSearch: begin
        if (abort) begin
          // tries deliberately kept so software can see how far the sweep got.
          state_d  = StIdle;
          cand_d   = '0;
          cnt_d    = '0;
          found_d  = 1'b0;
          exh_d    = 1'b0;
          result_d = '0;
        end else if (cnt_q == SettleLast) begin
          tries_d = tries_q + (WIDTH+1)'(1);
          if (match) begin
            state_d  = StDone;
            found_d  = 1'b1;
            result_d = cand_q;
          end else if (cand_q == CandMax) begin
            // Candidate parks at all-ones; no wrap back to zero.
            state_d = StDone;
            exh_d   = 1'b1;
          end else begin
            cand_d = cand_q + WIDTH'(1);
            cnt_d  = '0;
          end
        end else begin
          // Settling: match is ignored so comparator glitches have no effect.
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cand_q   <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      result_q <= '0;
      tries_q  <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      result_q <= result_d;
      tries_q  <= tries_d;
    end
  end

  assign candidate = cand_q;
  assign busy      = (state_q == StSearch);
  assign found     = found_q;
  assign exhausted = exh_q;
  assign result    = result_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_candidate_sweeper.sv
// Bench for candidate_sweeper: two instances (SETTLE=1 and SETTLE=3) share
// start/abort/rst and each sees its own comparator (candidate == target, with
// optional glitches on non-sampling cycles). The reference model tracks each
// sweep as "edges since start" and derives every output arithmetically.
module tb_candidate_sweeper;

  localparam int W     = 3;
  localparam int NCAND = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic [3:0] target;
  logic       glitch [2];
  logic       match  [2];
  logic [W-1:0] cand [2];
  logic [W-1:0] res  [2];
  logic [W:0]   tries[2];
  logic         busy [2];
  logic         found[2];
  logic         exh  [2];

  assign match[0] = ({1'b0, cand[0]} == target) | glitch[0];
  assign match[1] = ({1'b0, cand[1]} == target) | glitch[1];

  candidate_sweeper #(.WIDTH(W), .SETTLE(1)) u_dut_s1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .match     (match[0]),
    .candidate (cand[0]),
    .busy      (busy[0]),
    .found     (found[0]),
    .exhausted (exh[0]),
    .result    (res[0]),
    .tries     (tries[0])
  );

  candidate_sweeper #(.WIDTH(W), .SETTLE(3)) u_dut_s3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .match     (match[1]),
    .candidate (cand[1]),
    .busy      (busy[1]),
    .found     (found[1]),
    .exhausted (exh[1]),
    .result    (res[1]),
    .tries     (tries[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model. While sweeping, t = edges since the start edge.
  int m_sweep[2] = '{0, 0};
  int m_t    [2] = '{0, 0};
  int m_kend [2] = '{0, 0};
  int m_hit  [2] = '{0, 0};
  int m_cand [2] = '{0, 0};
  int m_found[2] = '{0, 0};
  int m_exh  [2] = '{0, 0};
  int m_res  [2] = '{0, 0};
  int m_tries[2] = '{0, 0};

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // A glitch is safe unless this edge is the one that samples match.
  function automatic bit glitch_ok(input int i);
    int s = settle_of(i);
    return !(m_sweep[i] != 0 && (m_t[i] % s) == s - 1);
  endfunction

  task automatic model_edge(input int i, input bit s_in, input bit a_in, input bit r_in);
    int s = settle_of(i);
    if (r_in) begin
      m_sweep[i] = 0; m_cand[i] = 0; m_found[i] = 0; m_exh[i] = 0;
      m_res[i] = 0; m_tries[i] = 0;
    end else if (m_sweep[i] != 0) begin
      if (a_in) begin
        m_sweep[i] = 0; m_tries[i] = m_t[i] / s; m_cand[i] = 0;
        m_found[i] = 0; m_exh[i] = 0; m_res[i] = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] == (m_kend[i] + 1) * s) begin
          m_sweep[i] = 0;
          m_cand[i]  = m_kend[i];
          m_found[i] = m_hit[i];
          m_exh[i]   = (m_hit[i] != 0) ? 0 : 1;
          m_res[i]   = (m_hit[i] != 0) ? m_kend[i] : 0;
          m_tries[i] = m_kend[i] + 1;
        end
      end
    end else if (s_in) begin
      m_sweep[i] = 1;
      m_t[i]     = 0;
      m_hit[i]   = (int'(target) < NCAND) ? 1 : 0;
      m_kend[i]  = (m_hit[i] != 0) ? int'(target) : NCAND - 1;
    end
  endtask

  task automatic check_dut(input int i);
    int s = settle_of(i);
    int e_cand, e_tries, e_busy, e_found, e_exh, e_res;
    if (m_sweep[i] != 0) begin
      e_cand = m_t[i] / s; e_tries = m_t[i] / s; e_busy = 1;
      e_found = 0; e_exh = 0; e_res = 0;
    end else begin
      e_cand = m_cand[i]; e_tries = m_tries[i]; e_busy = 0;
      e_found = m_found[i]; e_exh = m_exh[i]; e_res = m_res[i];
    end
    check_eq($sformatf("s%0d.candidate", s), int'(cand[i]),  e_cand);
    check_eq($sformatf("s%0d.busy", s),      int'(busy[i]),  e_busy);
    check_eq($sformatf("s%0d.found", s),     int'(found[i]), e_found);
    check_eq($sformatf("s%0d.exhausted", s), int'(exh[i]),   e_exh);
    check_eq($sformatf("s%0d.result", s),    int'(res[i]),   e_res);
    check_eq($sformatf("s%0d.tries", s),     int'(tries[i]), e_tries);
  endtask

  task automatic step(input bit s, input bit a, input bit r, input bit g0, input bit g1);
    start     = s;
    abort     = a;
    rst       = r;
    glitch[0] = g0 && glitch_ok(0);
    glitch[1] = g1 && glitch_ok(1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, s, a, r);
    #1;
    for (int i = 0; i < 2; i++) check_dut(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; target = 4'd5;
    glitch[0] = 1'b0; glitch[1] = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Match on candidate 5.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);

    // No match anywhere: exhausted, candidate parks at all-ones.
    target = 4'd8;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(26);

    // Glitch during the first settle cycle of candidate 1 on the SETTLE=3 unit.
    target = 4'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) step(1'b0, 1'b0, 1'b0, 1'b0, m_t[1] == 3);

    // Reset mid-sweep while the SETTLE=1 unit shows candidate 3.
    target = 4'd6;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(24);

    // Start ignored mid-sweep, then abort, then a clean sweep.
    target = 4'd4;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);

    // Restart straight from done with a new target.
    target = 4'd5;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(22);
    target = 4'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Random traffic; target only moves while neither unit is sweeping.
    for (int k = 0; k < 2500; k++) begin
      if (m_sweep[0] == 0 && m_sweep[1] == 0 && $urandom_range(0, 3) == 0)
        target = 4'($urandom_range(0, 8));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/candidate_sweeper.md
Name: candidate_sweeper

Overview:
Sequential search engine that drives the B-side of a WIDTH-bit equality comparator and waits for its match flag. It sweeps candidate values 0 .. 2^WIDTH-1, waits SETTLE cycles per candidate, and samples the comparator result. It stops on the first match (found) or after the last value (exhausted). It sits upstream of the 3-bit equality comparator and is its driving end: the comparator consumes two values and reports equality, and this block produces the values and consumes the report.

Parameters:
WIDTH, 3, candidate/result width in bits (>=1)
SETTLE, 1, cycles each candidate is held before match is sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
abort  in  1  cancels an active sweep; honoured only in SEARCH
match  in  1  equality result from external comparator for current candidate
candidate  out  WIDTH  value presented to comparator B input
busy  out  1  high while in SEARCH
found  out  1  sweep ended on a match; held until next start/abort/reset
exhausted  out  1  sweep ended with no match; held until next start/abort/reset
result  out  WIDTH  matching candidate, valid when found=1; 0 otherwise
tries  out  WIDTH+1  number of candidates sampled in the current/last sweep

Behaviour:
- Reset: synchronous, active-high, dominates all inputs. Sets state=IDLE, candidate=0, busy=0, found=0, exhausted=0, result=0, tries=0, settle_cnt=0.
- Reset asserted mid-sweep gives the same values on the next edge. No partial result is kept.
- FSM has 3 states: IDLE, SEARCH, DONE. busy = (state==SEARCH), decoded from registered state.
- IDLE/DONE with start=1:
  - Next state SEARCH.
  - candidate=0, settle_cnt=0, tries=0.
  - found=0, exhausted=0, result=0.
- SEARCH, per candidate:
  - settle_cnt counts 0..SETTLE-1. candidate stays constant.
  - match is ignored while settle_cnt<SETTLE-1, so glitches during settling have no effect.
  - On the edge where settle_cnt==SETTLE-1, match is sampled and tries increments. Then:
    - match=1: result=candidate, found=1, next state DONE. candidate holds.
    - match=0 and candidate==2^WIDTH-1: exhausted=1, next state DONE. candidate holds at all-ones with no wrap.
    - otherwise: candidate+1, settle_cnt=0, stay in SEARCH.
- start during SEARCH is ignored.
- abort during SEARCH: next state IDLE, candidate=0, settle_cnt=0, found=0, exhausted=0, result=0. tries keeps its value.
- abort and the final sample on the same edge: abort wins.
- abort outside SEARCH is ignored.
- DONE: outputs are held stable indefinitely. A new start restarts the sweep as described above.
- found and exhausted are never high together.
- Latency, counted in edges from the edge that samples start:
  - match on candidate k: found rises after (k+1)*SETTLE+1 edges.
  - no match: exhausted rises after 2^WIDTH*SETTLE+1 edges.
- tries at DONE: k+1 on a match, 2^WIDTH when exhausted. The counter is WIDTH+1 bits, so 2^WIDTH fits without overflow.
- The block does no arithmetic on match. The comparator is external and combinational. The block assumes comparator delay fits within SETTLE cycles.

Test Plan:
- WIDTH=3, SETTLE=1, comparator model A=5; pulse start → busy high for 6 cycles, candidate steps 0..5, found=1 two edges after start+5 (edge 7), result=5, tries=6, candidate holds 5.
- WIDTH=3, SETTLE=1, match tied 0; start → exhausted=1 at edge 9, found=0, tries=8, candidate=7 (no wrap to 0), busy=0.
- WIDTH=3, SETTLE=3, A=2, match pulsed high during the first (non-sampling) settle cycle of candidate 1 → glitch ignored; found at edge 10, result=2, tries=3.
- A=6, SETTLE=1: assert rst while candidate=3 → next edge all outputs 0, state IDLE. Then start → clean sweep, result=6, tries=7.
- A=4: start pulsed again at candidate=2 (ignored, candidate continues to 3). abort at candidate=3 → IDLE, candidate=0, found=exhausted=0. Then start → found, result=4.
- From DONE with found=1, result=5: change A to 1 and pulse start → found/result clear on that edge, new found with result=1, tries=2.
